wb_unit: RTL

// - Registered, parametrised writeback stage between MEM and the register file / CPSR.
// - Accepts one retiring op per cycle (NOP/ALU/CMP/LD); drives one-cycle rd and CPSR write pulses.
// - Adds what the combinational stage lacked: registered outputs, explicit write-enable defaults,

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_ld_timer.sv | 29 ++
 rtl/wb_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: retiring-op codes and FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_NOP = 2'd0,
    WB_ALU = 2'd1,
    WB_CMP = 2'd2,
    WB_LD  = 2'd3
  } wb_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_ld_timer.sv
// Load-wait timer: cleared on entry to the wait state, counts while enabled,
// flags the last permitted wait cycle through tc.
module wb_ld_timer #(
  parameter int unsigned TMR_W      = 4,
  parameter int unsigned LD_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TMR_W'(1);
    end
  end

  // tc is high during the LD_TIMEOUT-th wait cycle (count started at 0)
  assign tc = en & (count == TMR_W'(LD_TIMEOUT - 1));

endmodule

// File: rtl/wb_unit.sv
// Registered writeback stage: retires NOP/ALU/CMP/LD ops into register-file and
// CPSR write pulses, stalls upstream on late load data, aborts stuck loads.
module wb_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_NUM_W   = 4,
  parameter int unsigned CPSR_W     = 32,
  parameter int unsigned LD_TIMEOUT = 15,
  parameter int unsigned TMR_W      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic                in_set_flags,
  input  logic [RD_NUM_W-1:0] in_rd_num,
  input  logic [DATA_W-1:0]   in_result,
  input  logic [CPSR_W-1:0]   in_cpsr,
  input  logic                dmem_valid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                rd_write_en,
  output logic [RD_NUM_W-1:0] rd_num,
  output logic [DATA_W-1:0]   rd_val,
  output logic                cpsr_write_en,
  output logic [CPSR_W-1:0]   cpsr_out,
  output logic                ld_timeout_err,
  output logic [CNT_W-1:0]    retired_cnt
);

  wb_state_e           state;
  wb_op_e              op;
  logic [RD_NUM_W-1:0] ld_rd;
  logic                accept;
  logic                in_wait;
  logic                start_wait;
  logic                tmr_tc;

  assign op         = wb_op_e'(in_op);
  // Gated by rst_n so the stage never advertises ready during a reset cycle.
  assign in_ready   = rst_n & (state == ST_IDLE);
  assign accept     = in_valid & in_ready;
  assign in_wait    = (state == ST_LD_WAIT);
  assign start_wait = accept & (op == WB_LD) & ~dmem_valid;

  wb_ld_timer #(
    .TMR_W      (TMR_W),
    .LD_TIMEOUT (LD_TIMEOUT)
  ) u_ld_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_wait),
    .en    (in_wait),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ld_rd          <= '0;
      rd_write_en    <= 1'b0;
      rd_num         <= '0;
      rd_val         <= '0;
      cpsr_write_en  <= 1'b0;
      cpsr_out       <= '0;
      ld_timeout_err <= 1'b0;
      retired_cnt    <= '0;
    end else begin
      rd_write_en    <= 1'b0;
      cpsr_write_en  <= 1'b0;
      ld_timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              WB_ALU: begin
                rd_write_en <= 1'b1;
                rd_num      <= in_rd_num;
                rd_val      <= in_result;
                if (in_set_flags) begin
                  cpsr_write_en <= 1'b1;
                  cpsr_out      <= in_cpsr;
                end
                retired_cnt <= retired_cnt + CNT_W'(1);
              end
              WB_CMP: begin
                cpsr_write_en <= 1'b1;
                cpsr_out      <= in_cpsr;
                retired_cnt   <= retired_cnt + CNT_W'(1);
              end
              WB_LD: begin
                if (dmem_valid) begin
                  rd_write_en <= 1'b1;
                  rd_num      <= in_rd_num;
                  rd_val      <= dmem_rdata;
                  retired_cnt <= retired_cnt + CNT_W'(1);
                end else begin
                  ld_rd <= in_rd_num;
                  state <= ST_LD_WAIT;
                end
              end
              default: ;
            endcase
          end
        end
        ST_LD_WAIT: begin
          // Data arriving on the terminal cycle still completes the load.
          if (dmem_valid) begin
            rd_write_en <= 1'b1;
            rd_num      <= ld_rd;
            rd_val      <= dmem_rdata;
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= ST_IDLE;
          end else if (tmr_tc) begin
            ld_timeout_err <= 1'b1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
